// File: rtl/chan_cmd_arbiter.sv
// Packet-granular round-robin arbiter sharing one channel TX FIFO between NUM_REQ command
// sources, with a stall watchdog that closes a packet whose source stops mid-packet.
module chan_cmd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]  req_dest,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           chan_tx_fifo_data,
    output logic [3:0]            chan_tx_fifo_dest,
    output logic                  chan_tx_fifo_last,
    output logic                  chan_tx_fifo_valid,
    input  logic                  chan_tx_fifo_ready,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  timeout_err,
    output logic [15:0]           abort_count
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PASS, ABORT} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [3:0]         dest_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [15:0]        abort_count_reg;

    logic [31:0]        data_arr [NUM_REQ];
    logic [3:0]         dest_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[32*gi +: 32];
            assign dest_arr[gi] = req_dest[4*gi +: 4];
        end
    endgenerate

    logic               sel_valid;
    logic               sel_last;
    logic [IDX_W-1:0]   ptr_next;

    assign sel_valid = req_valid[grant_idx_reg];
    assign sel_last  = req_last[grant_idx_reg];
    assign ptr_next  = (int'(grant_idx_reg) >= NUM_REQ - 1) ? '0 : grant_idx_reg + IDX_W'(1);

    // Scan from lowest to highest priority so the highest-priority valid requester is written last.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     scan_sum;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
            if (req_valid[scan_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_idx_reg   <= '0;
            dest_reg        <= '0;
            stall_cnt_reg   <= '0;
            abort_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        grant_idx_reg <= win_idx;
                        dest_reg      <= dest_arr[win_idx];
                        stall_cnt_reg <= '0;
                        state_reg     <= PASS;
                    end
                end
                PASS: begin
                    if (sel_valid && chan_tx_fifo_ready) begin
                        stall_cnt_reg <= '0;
                        if (sel_last) begin
                            ptr_reg   <= ptr_next;
                            state_reg <= IDLE;
                        end
                    end else if (!sel_valid) begin
                        // FIFO back-pressure (valid=1, ready=0) deliberately leaves the counter alone.
                        if (TIMEOUT != 0 && stall_cnt_reg == STALL_MAX)
                            state_reg <= ABORT;
                        else
                            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
                    end
                end
                ABORT: begin
                    if (chan_tx_fifo_ready) begin
                        if (abort_count_reg != 16'hFFFF)
                            abort_count_reg <= abort_count_reg + 16'd1;
                        ptr_reg   <= ptr_next;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready          = '0;
        chan_tx_fifo_valid = 1'b0;
        chan_tx_fifo_data  = '0;
        chan_tx_fifo_last  = 1'b0;
        timeout_err        = 1'b0;
        case (state_reg)
            PASS: begin
                chan_tx_fifo_valid       = sel_valid;
                chan_tx_fifo_data        = data_arr[grant_idx_reg];
                chan_tx_fifo_last        = sel_last;
                req_ready[grant_idx_reg] = chan_tx_fifo_ready;
            end
            ABORT: begin
                chan_tx_fifo_valid = 1'b1;
                chan_tx_fifo_last  = 1'b1;
                chan_tx_fifo_data  = 32'hDEAD_0000 | 32'(grant_idx_reg);
                timeout_err        = chan_tx_fifo_ready;
            end
            default: ;
        endcase
    end

    assign chan_tx_fifo_dest = dest_reg;
    assign grant_idx         = grant_idx_reg;
    assign abort_count       = abort_count_reg;

endmodule

// File: tb/tb_chan_cmd_arbiter.sv
// Scoreboard bench for chan_cmd_arbiter: a 2-requester instance with a short watchdog and a
// 3-requester instance with the watchdog disabled, both stepped from one sequencing process.
module tb_chan_cmd_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
        logic [1:0]  src;
        logic        is_abort;
    } beat_t;

    logic clk;
    logic rst;

    logic [63:0] a_req_data;
    logic [7:0]  a_req_dest;
    logic [1:0]  a_req_last, a_req_valid, a_req_ready;
    logic [31:0] a_data;
    logic [3:0]  a_dest;
    logic        a_last, a_valid, a_ready, a_terr;
    logic [0:0]  a_grant;
    logic [15:0] a_abort_cnt;

    logic [95:0] b_req_data;
    logic [11:0] b_req_dest;
    logic [2:0]  b_req_last, b_req_valid, b_req_ready;
    logic [31:0] b_data;
    logic [3:0]  b_dest;
    logic        b_last, b_valid, b_ready, b_terr;
    logic [1:0]  b_grant;
    logic [15:0] b_abort_cnt;

    chan_cmd_arbiter #(.NUM_REQ(2), .IDX_W(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_data(a_req_data), .req_dest(a_req_dest), .req_last(a_req_last),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .chan_tx_fifo_data(a_data), .chan_tx_fifo_dest(a_dest), .chan_tx_fifo_last(a_last),
        .chan_tx_fifo_valid(a_valid), .chan_tx_fifo_ready(a_ready),
        .grant_idx(a_grant), .timeout_err(a_terr), .abort_count(a_abort_cnt)
    );

    chan_cmd_arbiter #(.NUM_REQ(3), .IDX_W(2), .TIMEOUT(0)) dut3 (
        .clk(clk), .rst(rst),
        .req_data(b_req_data), .req_dest(b_req_dest), .req_last(b_req_last),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .chan_tx_fifo_data(b_data), .chan_tx_fifo_dest(b_dest), .chan_tx_fifo_last(b_last),
        .chan_tx_fifo_valid(b_valid), .chan_tx_fifo_ready(b_ready),
        .grant_idx(b_grant), .timeout_err(b_terr), .abort_count(b_abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t srca_q [2][$];
    beat_t srcb_q [3][$];
    beat_t expa_q [$];
    beat_t expb_q [$];
    int    beat_cyc_q [$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_terr  = 0;
    int   n_beats_a = 0;
    int   cyc = 0;
    logic rdy_cfg = 1'b1;
    logic [1:0] acca = '0;
    logic [2:0] accb = '0;
    int   t0;
    logic [31:0] held_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (srca_q[i].size() > 0) begin
                a_req_valid[i]       = 1'b1;
                a_req_data[32*i +: 32] = srca_q[i][0].data;
                a_req_last[i]        = srca_q[i][0].last;
                a_req_dest[4*i +: 4] = srca_q[i][0].dest;
            end else begin
                a_req_valid[i]       = 1'b0;
                a_req_data[32*i +: 32] = '0;
                a_req_last[i]        = 1'b0;
                a_req_dest[4*i +: 4] = '0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (srcb_q[i].size() > 0) begin
                b_req_valid[i]       = 1'b1;
                b_req_data[32*i +: 32] = srcb_q[i][0].data;
                b_req_last[i]        = srcb_q[i][0].last;
                b_req_dest[4*i +: 4] = srcb_q[i][0].dest;
            end else begin
                b_req_valid[i]       = 1'b0;
                b_req_data[32*i +: 32] = '0;
                b_req_last[i]        = 1'b0;
                b_req_dest[4*i +: 4] = '0;
            end
        end
        a_ready = rdy_cfg;
        b_ready = 1'b1;
    endtask

    task automatic monitor();
        beat_t e;
        acca = a_req_valid & a_req_ready;
        accb = b_req_valid & b_req_ready;
        if (a_terr) n_terr++;
        if (a_valid && a_ready) begin
            n_beats_a++;
            beat_cyc_q.push_back(cyc);
            $display("[TB] A beat cyc=%0d grant=%0d data=%h last=%0d dest=%0d",
                     cyc, a_grant, a_data, a_last, a_dest);
            if (expa_q.size() == 0) begin
                check("a_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = expa_q.pop_front();
                check("a_data",  a_data, e.data);
                check("a_last",  32'(a_last), 32'(e.last));
                check("a_dest",  32'(a_dest), 32'(e.dest));
                check("a_grant", 32'(a_grant), 32'(e.src));
                check("a_terr",  32'(a_terr), 32'(e.is_abort));
                check("a_rdy_mask", 32'(a_req_ready & ~(2'b01 << a_grant)), 32'd0);
            end
        end
        if (b_valid && b_ready) begin
            $display("[TB] B beat cyc=%0d grant=%0d data=%h last=%0d dest=%0d",
                     cyc, b_grant, b_data, b_last, b_dest);
            if (expb_q.size() == 0) begin
                check("b_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = expb_q.pop_front();
                check("b_data",  b_data, e.data);
                check("b_last",  32'(b_last), 32'(e.last));
                check("b_dest",  32'(b_dest), 32'(e.dest));
                check("b_grant", 32'(b_grant), 32'(e.src));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) if (acca[i] && srca_q[i].size() > 0) void'(srca_q[i].pop_front());
        for (int i = 0; i < 3; i++) if (accb[i] && srcb_q[i].size() > 0) void'(srcb_q[i].pop_front());
        drive();
        @(negedge clk);
        monitor();
    endtask

    // Queue one packet on a source and its expected beats on the scoreboard.
    task automatic send(input int dsel, input int src, input int n, input logic [31:0] base,
                        input logic [3:0] dest, input bit close);
        beat_t b;
        for (int w = 0; w < n; w++) begin
            b.data     = base + 32'(w);
            b.last     = close && (w == n - 1);
            b.dest     = dest;
            b.src      = 2'(src);
            b.is_abort = 1'b0;
            if (dsel == 0) begin
                srca_q[src].push_back(b);
                expa_q.push_back(b);
            end else begin
                srcb_q[src].push_back(b);
                expb_q.push_back(b);
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((expa_q.size() > 0 || expb_q.size() > 0) && n < bound) begin
            step();
            n++;
        end
        if (expa_q.size() > 0 || expb_q.size() > 0) begin
            check("drain_timeout", 32'(expa_q.size() + expb_q.size()), 32'd0);
            expa_q.delete();
            expb_q.delete();
        end
        step();
        step();
    endtask

    task automatic wait_beats(input int target, input int bound);
        int n = 0;
        while (n_beats_a < target && n < bound) begin
            step();
            n++;
        end
        check("wait_beats_timeout", 32'(n_beats_a >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t ab;
        rst = 1'b1;
        a_req_data = '0; a_req_dest = '0; a_req_last = '0; a_req_valid = '0; a_ready = 1'b1;
        b_req_data = '0; b_req_dest = '0; b_req_last = '0; b_req_valid = '0; b_ready = 1'b1;
        drive();
        @(negedge clk);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_ready", 32'(a_req_ready), 32'd0);
        check("rst_last",  32'(a_last), 32'd0);
        check("rst_data",  a_data, 32'd0);
        check("rst_dest",  32'(a_dest), 32'd0);
        check("rst_grant", 32'(a_grant), 32'd0);
        check("rst_terr",  32'(a_terr), 32'd0);
        check("rst_abort_cnt", 32'(a_abort_cnt), 32'd0);
        rst = 1'b0;

        // Two sources, two 2-word packets each: strict alternation starting at req0.
        send(0, 0, 2, 32'hA0A0_0000, 4'h2, 1);
        send(0, 1, 2, 32'hB1B1_0000, 4'h7, 1);
        send(0, 0, 2, 32'hA0A0_0010, 4'h2, 1);
        send(0, 1, 2, 32'hB1B1_0010, 4'h7, 1);
        drain(60);

        // Single source: three consecutive beats, first one cycle after valid rises.
        beat_cyc_q.delete();
        send(0, 0, 3, 32'hA1A1_0001, 4'h5, 1);
        step();
        t0 = cyc;
        drain(30);
        check("t1_nbeats", 32'(beat_cyc_q.size()), 32'd3);
        if (beat_cyc_q.size() == 3) begin
            check("t1_first_beat_cyc", 32'(beat_cyc_q[0]), 32'(t0 + 1));
            check("t1_last_beat_cyc",  32'(beat_cyc_q[2]), 32'(t0 + 3));
        end

        // FIFO back-pressure far longer than the watchdog: no abort, data held.
        send(0, 0, 4, 32'hC3C3_0000, 4'h3, 1);
        wait_beats(n_beats_a + 1, 20);
        rdy_cfg = 1'b0;
        step();
        held_data = a_data;
        repeat (50) step();
        check("bp_valid", 32'(a_valid), 32'd1);
        check("bp_data_held", a_data, held_data);
        check("bp_data_exp", a_data, (expa_q.size() > 0) ? expa_q[0].data : 32'hFFFF_FFFF);
        check("bp_abort_cnt", 32'(a_abort_cnt), 32'd0);
        check("bp_terr_cnt", 32'(n_terr), 32'd0);
        rdy_cfg = 1'b1;
        drain(30);

        // req1 stalls after one word: abort word closes the packet, then req0 is next.
        send(0, 1, 1, 32'h4444_0000, 4'h9, 0);
        ab.data = 32'hDEAD_0001; ab.last = 1'b1; ab.dest = 4'h9; ab.src = 2'd1; ab.is_abort = 1'b1;
        expa_q.push_back(ab);
        drain(60);
        check("t4_abort_cnt", 32'(a_abort_cnt), 32'd1);
        check("t4_terr_pulses", 32'(n_terr), 32'd1);
        send(0, 0, 2, 32'hA4A4_0000, 4'h1, 1);
        send(0, 1, 2, 32'hB4B4_0000, 4'h6, 1);
        drain(40);

        // Reset mid-packet while stalled on req1's last word; ptr would otherwise favour req1.
        send(0, 0, 2, 32'hA5A5_0000, 4'h4, 1);
        drain(20);
        send(0, 1, 2, 32'hB5B5_0000, 4'h8, 1);
        wait_beats(n_beats_a + 1, 20);
        rdy_cfg = 1'b0;
        repeat (3) step();
        check("pre_rst_valid", 32'(a_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(a_valid), 32'd0);
        check("rst_mid_ready", 32'(a_req_ready), 32'd0);
        check("rst_mid_last",  32'(a_last), 32'd0);
        for (int i = 0; i < 2; i++) srca_q[i].delete();
        expa_q.delete();
        acca = '0;
        rdy_cfg = 1'b1;
        drive();
        #2;
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(a_valid), 32'd0);
        check("post_rst_dest",  32'(a_dest), 32'd0);
        check("post_rst_grant", 32'(a_grant), 32'd0);
        check("post_rst_abort_cnt", 32'(a_abort_cnt), 32'd0);
        send(0, 0, 1, 32'hA6A6_0000, 4'hC, 1);
        send(0, 1, 1, 32'hB6B6_0000, 4'hD, 1);
        drain(30);

        // Three requesters: move ptr to 1, then req2 beats req0 and the scan wraps to req0.
        send(1, 0, 1, 32'h6000_0000, 4'h1, 1);
        drain(20);
        send(1, 2, 1, 32'h6200_0000, 4'h2, 1);
        send(1, 0, 2, 32'h6000_0010, 4'h3, 1);
        drain(30);
        check("b_abort_cnt", 32'(b_abort_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
